// File: rtl/interrupt_controller.sv
// Two-source interrupt controller: sync, pending, mask, priority, in-service.
// Define INTC_NEST_EN to let src1 preempt an in-service src0.
module interrupt_controller #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0100
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  irqIn,
    input  logic        maskWrite,
    input  logic [1:0]  maskData,
    input  logic        intAck,
    input  logic        intDone,
    output logic        intReq,
    output logic [1:0]  intSel,
    output logic [1:0]  intLvl,
    output logic [15:0] intVector,
    output logic [1:0]  intPending
);

    typedef enum logic {IDLE, REQ} state_e;

    logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
    logic [1:0] hist_q, hist_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] mask_q, mask_d;
    logic [1:0] svc_q, svc_d;
    logic [1:0] sel_q, sel_d;
    state_e     state_q, state_d;

    logic [1:0] synced;
    logic [1:0] rise;
    logic [1:0] elig;
    logic [1:0] lvl;
    logic [1:0] ack_clr;
    logic       ack_ok;

    always_comb begin
        sync0_d = {sync0_q[SYNC_STAGES-2:0], irqIn[0]};
        sync1_d = {sync1_q[SYNC_STAGES-2:0], irqIn[1]};
        synced  = {sync1_q[SYNC_STAGES-1], sync0_q[SYNC_STAGES-1]};
        hist_d  = synced;
        rise    = synced & ~hist_q;
    end

    always_comb begin
        lvl = 2'd0;
        if (svc_q[1]) begin
            lvl = 2'd2;
        end else if (svc_q[0]) begin
            lvl = 2'd1;
        end
    end

    // A source may only interrupt a strictly lower service level.
    always_comb begin
`ifdef INTC_NEST_EN
        elig[0] = pend_q[0] & mask_q[0] & (lvl == 2'd0);
        elig[1] = pend_q[1] & mask_q[1] & (lvl != 2'd2);
`else
        elig = pend_q & mask_q & {2{~|svc_q}};
`endif
    end

    always_comb begin
        ack_ok  = (state_q == REQ) && intAck;
        ack_clr = ack_ok ? sel_q : 2'b00;
        pend_d  = (pend_q & ~ack_clr) | rise;
        mask_d  = maskWrite ? maskData : mask_q;
    end

    // Completion retires the innermost handler before a new ack lands.
    always_comb begin
        svc_d = svc_q;
        if (intDone) begin
            if (svc_d[1]) begin
                svc_d[1] = 1'b0;
            end else if (svc_d[0]) begin
                svc_d[0] = 1'b0;
            end
        end
        svc_d = svc_d | ack_clr;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    sel_d   = elig[1] ? 2'b10 : 2'b01;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (intAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync0_q <= '0;
            sync1_q <= '0;
            hist_q  <= 2'b00;
            pend_q  <= 2'b00;
            mask_q  <= 2'b00;
            svc_q   <= 2'b00;
            sel_q   <= 2'b00;
            state_q <= IDLE;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            hist_q  <= hist_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            svc_q   <= svc_d;
            sel_q   <= sel_d;
            state_q <= state_d;
        end
    end

    assign intReq     = (state_q == REQ);
    assign intSel     = intReq ? sel_q : 2'b00;
    assign intLvl     = lvl;
    assign intPending = pend_q;
    assign intVector  = !intReq  ? 16'h0000 :
                        sel_q[1] ? VEC_BASE + 16'd4 : VEC_BASE;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_interrupt_controller;

    localparam int          S  = 2;
    localparam logic [15:0] VB = 16'h0100;
`ifdef INTC_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  irqIn = 2'b00;
    logic        maskWrite = 1'b0;
    logic [1:0]  maskData = 2'b00;
    logic        intAck = 1'b0;
    logic        intDone = 1'b0;
    logic        intReq;
    logic [1:0]  intSel;
    logic [1:0]  intLvl;
    logic [15:0] intVector;
    logic [1:0]  intPending;

    int checks = 0;
    int failures = 0;

    interrupt_controller #(.SYNC_STAGES(S), .VEC_BASE(VB)) dut (
        .CLK(CLK), .Reset(Reset), .irqIn(irqIn),
        .maskWrite(maskWrite), .maskData(maskData),
        .intAck(intAck), .intDone(intDone),
        .intReq(intReq), .intSel(intSel), .intLvl(intLvl),
        .intVector(intVector), .intPending(intPending)
    );

    always #5 CLK = ~CLK;

    wire [22:0] got = {intReq, intSel, intLvl, intVector, intPending};

    function automatic logic [22:0] pk(input logic r, input logic [1:0] s,
        input logic [1:0] l, input logic [15:0] v, input logic [1:0] p);
        return {r, s, l, v, p};
    endfunction

    task automatic chk(input string nm, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got req/sel/lvl/vec/pend=%h required=%h",
                     nm, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] irq, input logic mw,
        input logic [1:0] md, input logic ack, input logic done);
        irqIn = irq;
        maskWrite = mw;
        maskData = md;
        intAck = ack;
        intDone = done;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        drive(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_state", 23'd0);
        Reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  irq;
        logic        mw;
        logic [1:0]  md;
        logic        ack;
        logic        done;
        logic        req;
        logic [1:0]  sel;
        logic [1:0]  lvl;
        logic [15:0] vec;
        logic [1:0]  pend;
    } row_t;

    row_t tbl[18];

    function automatic row_t mk(input logic [1:0] irq, input logic mw,
        input logic [1:0] md, input logic ack, input logic done,
        input logic req, input logic [1:0] sel, input logic [1:0] lvl,
        input logic [15:0] vec, input logic [1:0] pend);
        row_t r;
        r.irq = irq; r.mw = mw; r.md = md; r.ack = ack; r.done = done;
        r.req = req; r.sel = sel; r.lvl = lvl; r.vec = vec; r.pend = pend;
        return r;
    endfunction

    // Reference model: sample history, pending bits and a stack of
    // in-service sources whose top defines the current level.
    logic [1:0] samp[$];
    logic [1:0] m_pend;
    logic [1:0] m_mask;
    int         stack[$];
    bit         m_req;
    int         m_sel;

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i <= S; i++) samp.push_back(2'b00);
        stack.delete();
        m_pend = 2'b00;
        m_mask = 2'b00;
        m_req = 1'b0;
        m_sel = 0;
    endtask

    task automatic model_edge();
        int lv;
        int win;
        int n;
        bit acked;
        logic [1:0] rise;
        logic [1:0] clr;
        lv = (stack.size() == 0) ? 0 : stack[$] + 1;
        win = -1;
        for (int s = 0; s < 2; s++) begin
            if (m_pend[s] && m_mask[s] && (s + 1 > lv) &&
                (NEST || stack.size() == 0))
                win = s;
        end
        acked = m_req && intAck;
        samp.push_back(irqIn);
        n = samp.size();
        rise = samp[n-1-S] & ~samp[n-2-S];
        clr = !acked ? 2'b00 : (m_sel == 1) ? 2'b10 : 2'b01;
        m_pend = (m_pend & ~clr) | rise;
        if (intDone && stack.size() > 0) void'(stack.pop_back());
        if (acked) stack.push_back(m_sel);
        if (!m_req && win >= 0) begin
            m_req = 1'b1;
            m_sel = win;
        end else if (acked) begin
            m_req = 1'b0;
        end
        if (maskWrite) m_mask = maskData;
    endtask

    function automatic logic [22:0] model_out();
        logic [1:0] l;
        l = (stack.size() == 0) ? 2'd0 : 2'(stack[$] + 1);
        if (!m_req) return pk(1'b0, 2'b00, l, 16'h0000, m_pend);
        return pk(1'b1, (m_sel == 1) ? 2'b10 : 2'b01, l,
                  VB + 16'(4 * m_sel), m_pend);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] flip;

        tbl[0]  = mk(2'b00, 1, 2'b11, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[1]  = mk(2'b01, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[2]  = mk(2'b01, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[3]  = mk(2'b01, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b01);
        tbl[4]  = mk(2'b01, 0, 2'b00, 0, 0, 1, 2'b01, 0, 16'h0100, 2'b01);
        tbl[5]  = mk(2'b01, 0, 2'b00, 1, 0, 0, 2'b00, 1, 16'h0000, 2'b00);
        tbl[6]  = mk(2'b01, 0, 2'b00, 0, 1, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[7]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[8]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[9]  = mk(2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b00);
        tbl[10] = mk(2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 0, 16'h0000, 2'b11);
        tbl[11] = mk(2'b11, 0, 2'b00, 0, 0, 1, 2'b10, 0, 16'h0104, 2'b11);
        tbl[12] = mk(2'b11, 0, 2'b00, 1, 0, 0, 2'b00, 2, 16'h0000, 2'b01);
        tbl[13] = mk(2'b11, 0, 2'b00, 0, 0, 0, 2'b00, 2, 16'h0000, 2'b01);
        tbl[14] = mk(2'b11, 0, 2'b00, 0, 1, 0, 2'b00, 0, 16'h0000, 2'b01);
        tbl[15] = mk(2'b11, 0, 2'b00, 0, 0, 1, 2'b01, 0, 16'h0100, 2'b01);
        tbl[16] = mk(2'b11, 0, 2'b00, 1, 0, 0, 2'b00, 1, 16'h0000, 2'b00);
        tbl[17] = mk(2'b11, 0, 2'b00, 0, 1, 0, 2'b00, 0, 16'h0000, 2'b00);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].irq, tbl[i].mw, tbl[i].md, tbl[i].ack, tbl[i].done);
            tick();
            chk($sformatf("row%0d", i),
                pk(tbl[i].req, tbl[i].sel, tbl[i].lvl, tbl[i].vec, tbl[i].pend));
        end

        // Masked source stays pending until the mask opens.
        do_reset();
        drive(2'b00, 1, 2'b01, 0, 0); tick();
        drive(2'b10, 0, 2'b00, 0, 0); tick(); tick(); tick();
        chk("mask_pend", pk(0, 2'b00, 0, 16'h0, 2'b10));
        tick();
        chk("mask_hold", pk(0, 2'b00, 0, 16'h0, 2'b10));
        drive(2'b10, 1, 2'b11, 0, 0); tick();
        chk("mask_wr_edge", pk(0, 2'b00, 0, 16'h0, 2'b10));
        drive(2'b10, 0, 2'b00, 0, 0); tick();
        chk("mask_open", pk(1, 2'b10, 0, 16'h0104, 2'b10));

        // src1 arriving while src0 is in service.
        do_reset();
        drive(2'b00, 1, 2'b11, 0, 0); tick();
        drive(2'b01, 0, 2'b00, 0, 0); tick(); tick(); tick(); tick();
        chk("nest_req0", pk(1, 2'b01, 0, 16'h0100, 2'b01));
        drive(2'b01, 0, 2'b00, 1, 0); tick();
        chk("nest_ack0", pk(0, 2'b00, 1, 16'h0, 2'b00));
        drive(2'b11, 0, 2'b00, 0, 0); tick(); tick(); tick();
        chk("nest_pend1", pk(0, 2'b00, 1, 16'h0, 2'b10));
        tick();
        if (NEST) begin
            chk("nest_req1", pk(1, 2'b10, 1, 16'h0104, 2'b10));
            drive(2'b11, 0, 2'b00, 1, 0); tick();
            chk("nest_lvl2", pk(0, 2'b00, 2, 16'h0, 2'b00));
            drive(2'b11, 0, 2'b00, 0, 1); tick();
            chk("nest_lvl1", pk(0, 2'b00, 1, 16'h0, 2'b00));
            tick();
            chk("nest_lvl0", pk(0, 2'b00, 0, 16'h0, 2'b00));
        end else begin
            chk("flat_block", pk(0, 2'b00, 1, 16'h0, 2'b10));
            tick();
            chk("flat_block2", pk(0, 2'b00, 1, 16'h0, 2'b10));
            drive(2'b11, 0, 2'b00, 0, 1); tick();
            chk("flat_done", pk(0, 2'b00, 0, 16'h0, 2'b10));
            drive(2'b11, 0, 2'b00, 0, 0); tick();
            chk("flat_req1", pk(1, 2'b10, 0, 16'h0104, 2'b10));
        end

        // New src0 edge lands on the same edge as its ack.
        do_reset();
        drive(2'b00, 1, 2'b11, 0, 0); tick();
        drive(2'b01, 0, 2'b00, 0, 0); tick();
        drive(2'b00, 0, 2'b00, 0, 0); tick();
        drive(2'b01, 0, 2'b00, 0, 0); tick(); tick();
        chk("same_req", pk(1, 2'b01, 0, 16'h0100, 2'b01));
        drive(2'b01, 0, 2'b00, 1, 0); tick();
        chk("same_ack", pk(0, 2'b00, 1, 16'h0, 2'b01));
        drive(2'b01, 0, 2'b00, 0, 1); tick();
        chk("same_done", pk(0, 2'b00, 0, 16'h0, 2'b01));
        drive(2'b01, 0, 2'b00, 0, 0); tick();
        chk("same_rereq", pk(1, 2'b01, 0, 16'h0100, 2'b01));

        // Reset during REQ, then a level held across release.
        do_reset();
        drive(2'b00, 1, 2'b11, 0, 0); tick();
        drive(2'b01, 0, 2'b00, 0, 0); tick(); tick(); tick(); tick();
        chk("rst_pre", pk(1, 2'b01, 0, 16'h0100, 2'b01));
        Reset = 1'b0;
        #1;
        chk("rst_async", 23'd0);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        tick(); tick();
        chk("rst_rel1", pk(0, 2'b00, 0, 16'h0, 2'b00));
        tick();
        chk("rst_rel2", pk(0, 2'b00, 0, 16'h0, 2'b01));
        tick();
        chk("rst_rel3", pk(0, 2'b00, 0, 16'h0, 2'b01));

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            flip[0] = ($urandom_range(0, 3) == 0);
            flip[1] = ($urandom_range(0, 3) == 0);
            drive(irqIn ^ flip, $urandom_range(0, 9) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
            @(posedge CLK);
            model_edge();
            #1;
            chk($sformatf("rand%0d", i), model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
